// File: rtl/sixteen_bit_cla_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// sixteen_bit_cla_subtractor_pipe
//
// Four-stage pipelined 16-bit subtractor. Each stage uses a 4-bit
// carry-lookahead slice and processes one nibble. Stage 3 is the output
// register. The subtraction is computed as A + ~B + ~borrowin.
// A single global advance signal moves the whole pipeline, so a stalled
// result holds every stage in place.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation on A/B/borrowin is valid
//   in_ready   block accepts an operation this cycle (= advance)
//   A, B       minuend, subtrahend (16 bits)
//   borrowin   borrow into bit 0
//   out_valid  diff/flags hold a valid result
//   out_ready  consumer takes the result this cycle
//   diff       A - B - borrowin mod 2^16
//   borrow     unsigned borrow out (A < B + borrowin)
//   overflow   signed overflow of the subtraction
//   zero       diff == 0
// -----------------------------------------------------------------------------
module sixteen_bit_cla_subtractor_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        borrowin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff,
    output logic        borrow,
    output logic        overflow,
    output logic        zero
);

    // 4-bit lookahead slice on a + ~b + cin; returns {cout, sum}.
    // Every carry is a flat sum-of-products of g/p/cin, with no ripple.
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & ~b;
        p    = a ^ ~b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Stage 0: nibble 0 result, carry, remaining operand nibbles
    logic        v0_q, v0_d, c0_q, c0_d;
    logic [3:0]  r0_q, r0_d;
    logic [15:4] a0_q, a0_d, b0_q, b0_d;
    // Stage 1
    logic        v1_q, v1_d, c1_q, c1_d;
    logic [7:0]  r1_q, r1_d;
    logic [15:8] a1_q, a1_d, b1_q, b1_d;
    // Stage 2
    logic        v2_q, v2_d, c2_q, c2_d;
    logic [11:0] r2_q, r2_d;
    logic [15:12] a2_q, a2_d, b2_q, b2_d;
    // Stage 3 = output register
    logic        ov_q, ov_d;
    logic [15:0] diff_q, diff_d;
    logic        borrow_q, borrow_d, overflow_q, overflow_d, zero_q, zero_d;

    logic [4:0]  s0, s1, s2, s3;
    logic        stall, advance;

    assign stall    = ov_q & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    assign s0 = cla4(A[3:0],     B[3:0],     ~borrowin);
    assign s1 = cla4(a0_q[7:4],  b0_q[7:4],  c0_q);
    assign s2 = cla4(a1_q[11:8], b1_q[11:8], c1_q);
    assign s3 = cla4(a2_q[15:12], b2_q[15:12], c2_q);

    // Next-state for every stage: shift one stage on advance, otherwise hold
    always_comb begin
        v0_d = v0_q; c0_d = c0_q; r0_d = r0_q; a0_d = a0_q; b0_d = b0_q;
        v1_d = v1_q; c1_d = c1_q; r1_d = r1_q; a1_d = a1_q; b1_d = b1_q;
        v2_d = v2_q; c2_d = c2_q; r2_d = r2_q; a2_d = a2_q; b2_d = b2_q;
        ov_d = ov_q; diff_d = diff_q; borrow_d = borrow_q;
        overflow_d = overflow_q; zero_d = zero_q;
        if (advance) begin
            v0_d = in_valid; c0_d = s0[4]; r0_d = s0[3:0];
            a0_d = A[15:4];  b0_d = B[15:4];
            v1_d = v0_q; c1_d = s1[4]; r1_d = {s1[3:0], r0_q};
            a1_d = a0_q[15:8]; b1_d = b0_q[15:8];
            v2_d = v1_q; c2_d = s2[4]; r2_d = {s2[3:0], r1_q};
            a2_d = a1_q[15:12]; b2_d = b1_q[15:12];
            ov_d       = v2_q;
            diff_d     = {s3[3:0], r2_q};
            borrow_d   = ~s3[4];
            // Operand sign bits were carried along with the top nibble
            overflow_d = (a2_q[15] != b2_q[15]) && (s3[3] != a2_q[15]);
            zero_d     = ({s3[3:0], r2_q} == 16'h0000);
        end else begin
            ov_d = ov_q;
        end
    end

    // Pipeline registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0; c0_q <= 1'b0; r0_q <= 4'h0; a0_q <= 12'h000; b0_q <= 12'h000;
            v1_q <= 1'b0; c1_q <= 1'b0; r1_q <= 8'h00; a1_q <= 8'h00; b1_q <= 8'h00;
            v2_q <= 1'b0; c2_q <= 1'b0; r2_q <= 12'h000; a2_q <= 4'h0; b2_q <= 4'h0;
            ov_q <= 1'b0; diff_q <= 16'h0000; borrow_q <= 1'b0;
            overflow_q <= 1'b0; zero_q <= 1'b0;
        end else begin
            v0_q <= v0_d; c0_q <= c0_d; r0_q <= r0_d; a0_q <= a0_d; b0_q <= b0_d;
            v1_q <= v1_d; c1_q <= c1_d; r1_q <= r1_d; a1_q <= a1_d; b1_q <= b1_d;
            v2_q <= v2_d; c2_q <= c2_d; r2_q <= r2_d; a2_q <= a2_d; b2_q <= b2_d;
            ov_q <= ov_d; diff_q <= diff_d; borrow_q <= borrow_d;
            overflow_q <= overflow_d; zero_q <= zero_d;
        end
    end

    assign out_valid = ov_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_sixteen_bit_cla_subtractor_pipe.sv
module tb_sixteen_bit_cla_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, borrowin, out_valid, out_ready;
    logic [15:0] A, B, diff;
    logic        borrow, overflow, zero;

    sixteen_bit_cla_subtractor_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .borrowin(borrowin), .out_valid(out_valid),
        .out_ready(out_ready), .diff(diff), .borrow(borrow),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        br;
        logic        ovf;
        logic        z;
    } vec_t;

    localparam int N = 11;
    vec_t vecs [N];
    int checks = 0;
    int errors = 0;

    function automatic logic [19:0] obs();
        return {out_valid, borrow, overflow, zero, diff};
    endfunction

    function automatic logic [19:0] expv(input vec_t v);
        return {1'b1, v.br, v.ovf, v.z, v.d};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        A = v.a; B = v.b; borrowin = v.bin; in_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        int next_in, next_out, stall_left, stall_seen, cyc;
        bit started, have_held, acc, exp_rdy;
        logic [15:0] held;

        //            a         b         bin   d         br    ov    z
        vecs[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{16'h00F0, 16'h000F, 1'b0, 16'h00E1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = 16'h0000; B = 16'h0000; borrowin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", obs(), 20'h00000);
        check("reset_in_ready", 20'(in_ready), 20'h00001);
        rst = 1'b0;

        // Single operations: latency exactly 4, then the full result
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1 check("single_in_ready", 20'(in_ready), 20'h00001);
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
                check("latency_not_early", 20'(out_valid), 20'h00000);
                @(posedge clk);
            end
            @(negedge clk);
            check($sformatf("single_vec%0d", i), obs(), expv(vecs[i]));
        end

        // Back-to-back stream: one result per cycle, in order
        for (int c = 0; c < N + 4; c++) begin
            @(negedge clk);
            if (c < N) drive(vecs[c]);
            else in_valid = 1'b0;
            if (c >= 4) check($sformatf("stream_vec%0d", c - 4), obs(), expv(vecs[c - 4]));
        end

        // Backpressure: 6 ops, out_ready low for 3 cycles at first result
        @(negedge clk);
        next_in = 0; next_out = 0; stall_left = 3; stall_seen = 0; cyc = 0;
        started = 1'b0; have_held = 1'b0; held = 16'h0000;
        while (next_out < 6 && cyc < 40) begin
            if (cyc != 0) @(negedge clk);
            if (out_valid && !started) started = 1'b1;
            if (started && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (next_in < 6) drive(vecs[next_in]);
            else in_valid = 1'b0;
            #1;
            exp_rdy = !(out_valid && !out_ready);
            check("bp_in_ready", 20'(in_ready), 20'(exp_rdy));
            if (!in_ready) stall_seen++;
            if (out_valid) begin
                check($sformatf("bp_result%0d", next_out), obs(), expv(vecs[next_out]));
                if (have_held) check("bp_diff_stable", 20'(diff), 20'(held));
                if (out_ready) next_out++;
            end
            held = diff;
            have_held = out_valid && !out_ready;
            acc = in_valid && exp_rdy;
            @(posedge clk);
            if (acc) next_in++;
            cyc++;
        end
        check("bp_all_results", 20'(next_out), 20'd6);
        check("bp_stall_cycles", 20'(stall_seen), 20'd3);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_no_duplicate", 20'(out_valid), 20'h00000);
        end

        // Reset mid-flight with 3 operations in the pipeline
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_outputs", obs(), 20'h00000);
        check("midrst_in_ready", 20'(in_ready), 20'h00001);
        rst = 1'b0;
        drive(vecs[3]);
        #1 check("post_rst_accept", 20'(in_ready), 20'h00001);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("midrst_no_stale", 20'(out_valid), 20'h00000);
            @(posedge clk);
        end
        @(negedge clk);
        check("post_rst_result", obs(), expv(vecs[3]));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_quiet", 20'(out_valid), 20'h00000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sixteen_bit_cla_subtractor_pipe.md
SIXTEEN_BIT_CLA_SUBTRACTOR_PIPE -- requirements
Module: sixteen_bit_cla_subtractor_pipe

Interface
REQ-001 Parameters: none; the datapath is fixed at 16 bits, organised as four 4-bit carry-lookahead slices.
REQ-002 The block SHALL use one clock, clk; reset is synchronous and active-high, named rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 in_valid  input  1  high when A, B and borrowin carry a valid operation.
REQ-006 in_ready  output  1  high when the block accepts an operation this cycle.
REQ-007 A  input  16  minuend.
REQ-008 B  input  16  subtrahend.
REQ-009 borrowin  input  1  borrow into bit 0.
REQ-010 out_valid  output  1  high when diff and the flags hold a valid result.
REQ-011 out_ready  input  1  high when the consumer takes the result this cycle.
REQ-012 diff  output  16  A - B - borrowin, modulo 2^16.
REQ-013 borrow  output  1  unsigned borrow out; high when A < B + borrowin.
REQ-014 overflow  output  1  signed two's-complement overflow of the subtraction.
REQ-015 zero  output  1  high when diff == 16'h0000.

Function
REQ-016 The block SHALL compute diff as A + ~B + cin, where cin = ~borrowin; borrow SHALL equal ~cout of slice 3.
REQ-017 Each slice SHALL use per-bit generate g = a&~b and propagate p = a^~b, with full lookahead for internal carries and for the slice carry-out, not a ripple chain.
REQ-018 Pipeline stage k (k = 0..3) SHALL compute nibble k in one cycle and register:
- nibble k of the result;
- the slice carry-out;
- the lower result nibbles already produced;
- the operand nibbles not yet consumed;
- one valid bit.
REQ-019 An operation accepted in cycle t SHALL drive its result on diff and the flags, with out_valid high, from cycle t+4 onward; latency is fixed at 4.
REQ-020 The block SHALL assert overflow when (A[15] != B[15]) && (diff[15] != A[15]), using the operand sign bits carried to stage 3.
REQ-021 The block SHALL compute zero from the final registered diff.
REQ-022 Let stall = out_valid && !out_ready; advance = !stall.
REQ-023 in_ready SHALL equal advance, combinationally; it does not depend on in_valid.
REQ-024 An operation is accepted when in_valid && in_ready.
REQ-025 When advance is high, every stage SHALL load from its predecessor.
- Stage 0 loads in_valid and the inputs.
- Stages with valid = 0 carry bubbles.
REQ-026 When stall is high, all stage registers, including the output register, SHALL hold; diff and the flags SHALL stay stable while out_valid is high and out_ready is low.
REQ-027 The block SHALL not lose, duplicate or reorder results.
REQ-028 Throughput SHALL be one operation per cycle while out_ready is held high.
REQ-029 Bubbles: out_valid low with out_ready low is not a stall; the pipeline advances and bubbles collapse.
REQ-030 When out_valid is low, diff and the flags SHALL hold their last values; only out_valid qualifies them.

Reset
REQ-031 While rst is high at a clock edge, all valid bits SHALL clear, and diff, borrow, overflow and zero SHALL load 0.
REQ-032 Reset SHALL take priority over stall and accept.
REQ-033 Operations in flight when rst is asserted SHALL be discarded, never emitted.
REQ-034 in_ready SHALL be 1 in the cycle after reset, because out_valid is 0.
REQ-035 An operation presented in the first cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-036 The bench SHALL check: A=16'h0005, B=16'h0003, borrowin=0 -> after 4 cycles diff=16'h0002, borrow=0, overflow=0, zero=0.
REQ-037 The bench SHALL check: A=16'h0000, B=16'h0001, borrowin=0 -> diff=16'hFFFF, borrow=1, overflow=0, zero=0.
REQ-038 The bench SHALL check: A=16'h8000, B=16'h0001, borrowin=0 -> diff=16'h7FFF, borrow=0, overflow=1.
REQ-039 The bench SHALL check: A=16'h1234, B=16'h1233, borrowin=1 -> diff=16'h0000, zero=1, borrow=0; also A=16'h00F0, B=16'h000F, borrowin=0 -> diff=16'h00E1, which crosses nibble carries.
REQ-040 The bench SHALL check backpressure:
- stimulus: 6 back-to-back operations, with out_ready held low for 3 cycles once the first result appears;
- in_ready low exactly during stall cycles;
- diff stable during the stall;
- all 6 results emitted in order, none dropped or repeated.
REQ-041 The bench SHALL check reset mid-flight: rst pulsed one cycle with 3 operations in flight -> next cycle out_valid=0, diff=0, all flags 0, in_ready=1; no stale result ever appears on out_valid.
